// File: rtl/stopwatch_ctrl_if.sv
// Key inputs and display/status outputs of the stopwatch controller.
// The controller uses the slave modport; the board side (or a bench) uses master.
interface stopwatch_ctrl_if;
  logic       KEY_SS_N;
  logic       KEY_LR_N;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic       RUN_LED;
  logic       LAP_LED;
  logic       WRAP;

  modport master (
    output KEY_SS_N, KEY_LR_N,
    input  HEX0, HEX1, HEX2, HEX3, RUN_LED, LAP_LED, WRAP
  );

  modport slave (
    input  KEY_SS_N, KEY_LR_N,
    output HEX0, HEX1, HEX2, HEX3, RUN_LED, LAP_LED, WRAP
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch with debounced start/stop and lap/clear keys, lap freeze
// display and active-low seven-segment outputs.
//
// state | meaning
// IDLE  | count and prescaler held at zero
// RUN   | counting, live count displayed
// PAUSE | count and partial second frozen
// LAP   | counting, captured lap count displayed
module stopwatch_ctrl #(
  parameter int TICK_CNT = 50_000_000,
  parameter int DEB_CNT  = 1_000_000
) (
  input logic             CLK,
  input logic             RST,
  stopwatch_ctrl_if.slave sw
);

  localparam int PW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  state_t         state, state_n;
  logic [1:0]     key_m, key_s, deb, deb_d1, armed, press;
  logic [DW-1:0]  dcnt [2];
  logic [PW-1:0]  presc;
  logic [3:0]     sec_o, sec_t, min_o, min_t;
  logic [3:0]     sec_o_n, sec_t_n, min_o_n, min_t_n;
  logic [15:0]    lap_q, live, disp;
  logic           counting, tick, roll, ss_p, lr_p;
  logic           wrap_q, run_led_q, lap_led_q;

  // A key is armed only once it has been seen released, so one held through reset stays silent.
  always_ff @(posedge CLK) begin
    if (RST) begin
      key_m   <= '0;
      key_s   <= '0;
      deb     <= '1;
      deb_d1  <= '1;
      armed   <= '0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      key_m  <= {sw.KEY_LR_N, sw.KEY_SS_N};
      key_s  <= key_m;
      deb_d1 <= deb;
      for (int k = 0; k < 2; k++) begin
        if (key_s[k] == deb[k]) begin
          dcnt[k] <= '0;
        end else if (dcnt[k] == DW'(DEB_CNT - 1)) begin
          deb[k]  <= key_s[k];
          dcnt[k] <= '0;
        end else begin
          dcnt[k] <= dcnt[k] + 1'b1;
        end
        if (deb[k] && key_s[k]) armed[k] <= 1'b1;
      end
    end
  end

  assign press    = armed & deb_d1 & ~deb;
  assign ss_p     = press[0];
  assign lr_p     = press[1] & ~press[0];
  assign counting = (state == RUN) || (state == LAP);
  assign tick     = counting && (presc == PW'(TICK_CNT - 1));
  assign live     = {min_t, min_o, sec_t, sec_o};

  always_comb begin
    sec_o_n = sec_o;
    sec_t_n = sec_t;
    min_o_n = min_o;
    min_t_n = min_t;
    roll    = 1'b0;
    if (sec_o != 4'd9) sec_o_n = sec_o + 4'd1;
    else begin
      sec_o_n = 4'd0;
      if (sec_t != 4'd5) sec_t_n = sec_t + 4'd1;
      else begin
        sec_t_n = 4'd0;
        if (min_o != 4'd9) min_o_n = min_o + 4'd1;
        else begin
          min_o_n = 4'd0;
          if (min_t != 4'd5) min_t_n = min_t + 4'd1;
          else begin
            min_t_n = 4'd0;
            roll    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ss_p) state_n = RUN;
      RUN:     if (ss_p) state_n = PAUSE; else if (lr_p) state_n = LAP;
      LAP:     if (ss_p) state_n = PAUSE; else if (lr_p) state_n = RUN;
      PAUSE:   if (ss_p) state_n = RUN;   else if (lr_p) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      presc     <= '0;
      sec_o     <= '0;
      sec_t     <= '0;
      min_o     <= '0;
      min_t     <= '0;
      lap_q     <= '0;
      wrap_q    <= 1'b0;
      run_led_q <= 1'b0;
      lap_led_q <= 1'b0;
    end else begin
      state     <= state_n;
      run_led_q <= (state_n == RUN) || (state_n == LAP);
      lap_led_q <= (state_n == LAP);
      wrap_q    <= tick && roll;
      if (counting) presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        sec_o <= sec_o_n;
        sec_t <= sec_t_n;
        min_o <= min_o_n;
        min_t <= min_t_n;
      end
      // Lap takes the pre-tick count; the clear wins over nothing since PAUSE never ticks.
      if (state == RUN && !ss_p && lr_p) lap_q <= live;
      if (state == IDLE || (state == PAUSE && !ss_p && lr_p)) begin
        presc <= '0;
        sec_o <= '0;
        sec_t <= '0;
        min_o <= '0;
        min_t <= '0;
      end
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  assign disp       = (state == LAP) ? lap_q : live;
  assign sw.HEX0    = seg(disp[3:0]);
  assign sw.HEX1    = seg(disp[7:4]);
  assign sw.HEX2    = seg(disp[11:8]);
  assign sw.HEX3    = seg(disp[15:12]);
  assign sw.RUN_LED = run_led_q;
  assign sw.LAP_LED = lap_led_q;
  assign sw.WRAP    = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_CNT=10, DEB_CNT=4.
// A key driven low just after edge N first samples at N+1; its state change lands at N+7.
module tb_stopwatch_ctrl;
  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_CNT(10), .DEB_CNT(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .sw  (sw_if)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    chk(tag, {6'd0, obs}, {6'd0, exp});
  endtask

  initial begin
    RST = 1'b1;
    sw_if.KEY_SS_N = 1'b1;
    sw_if.KEY_LR_N = 1'b1;
    step(3);
    chk("rst_hex0", sw_if.HEX0, SEG[0]);
    chk("rst_hex3", sw_if.HEX3, SEG[0]);
    chk_bit("rst_run", sw_if.RUN_LED, 1'b0);
    chk_bit("rst_lap", sw_if.LAP_LED, 1'b0);
    chk_bit("rst_wrap", sw_if.WRAP, 1'b0);
    RST = 1'b0;
    step(10);

    // Bounce: never stable for 4 cycles
    for (int i = 0; i < 10; i++) begin
      sw_if.KEY_SS_N = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(2);
    end
    sw_if.KEY_SS_N = 1'b1;
    step(10);
    chk_bit("bounce_run", sw_if.RUN_LED, 1'b0);
    chk("bounce_hex0", sw_if.HEX0, SEG[0]);

    // Start latency: 2 sync + 4 debounce + 1 FSM edges; RUN edge is E6
    sw_if.KEY_SS_N = 1'b0;
    step(6);
    chk_bit("start_early", sw_if.RUN_LED, 1'b0);
    step(1);
    chk_bit("start_run", sw_if.RUN_LED, 1'b1);
    step(3);
    sw_if.KEY_SS_N = 1'b1;
    step(26);
    chk("sec2_hex0", sw_if.HEX0, SEG[2]);
    step(1);
    chk("sec3_hex0", sw_if.HEX0, SEG[3]);

    // Pause at 00:05 with prescaler at 7
    step(20);
    sw_if.KEY_SS_N = 1'b0;
    step(7);
    chk_bit("pause_run", sw_if.RUN_LED, 1'b0);
    chk("pause_hex0", sw_if.HEX0, SEG[5]);
    step(1);
    sw_if.KEY_SS_N = 1'b1;
    step(50);
    chk("frozen_hex0", sw_if.HEX0, SEG[5]);
    sw_if.KEY_SS_N = 1'b0;
    step(7);
    chk_bit("resume_run", sw_if.RUN_LED, 1'b1);
    step(2);
    chk("resume_r2", sw_if.HEX0, SEG[5]);
    step(1);
    chk("resume_r3", sw_if.HEX0, SEG[6]);
    sw_if.KEY_SS_N = 1'b1;

    // Lap at 00:12 (prescaler 2)
    step(55);
    sw_if.KEY_LR_N = 1'b0;
    step(7);
    chk_bit("lap_led", sw_if.LAP_LED, 1'b1);
    chk_bit("lap_run", sw_if.RUN_LED, 1'b1);
    chk("lap_hex0", sw_if.HEX0, SEG[2]);
    chk("lap_hex1", sw_if.HEX1, SEG[1]);
    step(1);
    sw_if.KEY_LR_N = 1'b1;
    step(20);
    chk("lapfrz_hex0", sw_if.HEX0, SEG[2]);
    step(12);
    sw_if.KEY_LR_N = 1'b0;
    step(7);
    chk_bit("unlap_led", sw_if.LAP_LED, 1'b0);
    chk("unlap_hex0", sw_if.HEX0, SEG[6]);
    chk("unlap_hex1", sw_if.HEX1, SEG[1]);
    step(1);
    sw_if.KEY_LR_N = 1'b1;

    // Pause at 00:17, then simultaneous SS+LR resumes without clearing
    step(5);
    sw_if.KEY_SS_N = 1'b0;
    step(7);
    chk_bit("pause2_run", sw_if.RUN_LED, 1'b0);
    chk("pause2_hex0", sw_if.HEX0, SEG[7]);
    step(1);
    sw_if.KEY_SS_N = 1'b1;
    step(10);
    sw_if.KEY_SS_N = 1'b0;
    sw_if.KEY_LR_N = 1'b0;
    step(7);
    chk_bit("both_run", sw_if.RUN_LED, 1'b1);
    chk_bit("both_lap", sw_if.LAP_LED, 1'b0);
    chk("both_hex0", sw_if.HEX0, SEG[7]);
    chk("both_hex1", sw_if.HEX1, SEG[1]);
    step(1);
    sw_if.KEY_SS_N = 1'b1;
    sw_if.KEY_LR_N = 1'b1;

    // Reset mid-LAP with SS held low through reset release
    step(10);
    sw_if.KEY_LR_N = 1'b0;
    step(7);
    chk_bit("lap2_led", sw_if.LAP_LED, 1'b1);
    sw_if.KEY_SS_N = 1'b0;
    RST = 1'b1;
    step(1);
    chk("rstlap_hex0", sw_if.HEX0, SEG[0]);
    chk("rstlap_hex1", sw_if.HEX1, SEG[0]);
    chk("rstlap_hex2", sw_if.HEX2, SEG[0]);
    chk("rstlap_hex3", sw_if.HEX3, SEG[0]);
    chk_bit("rstlap_run", sw_if.RUN_LED, 1'b0);
    chk_bit("rstlap_lap", sw_if.LAP_LED, 1'b0);
    sw_if.KEY_LR_N = 1'b1;
    step(2);
    RST = 1'b0;
    step(20);
    chk_bit("held_key_run", sw_if.RUN_LED, 1'b0);
    sw_if.KEY_SS_N = 1'b1;
    step(10);
    sw_if.KEY_SS_N = 1'b0;
    step(7);
    chk_bit("repress_run", sw_if.RUN_LED, 1'b1);
    step(1);
    sw_if.KEY_SS_N = 1'b1;

    // Full hour: RUN edge W0, 01:00 at W0+600, 59:58 at W0+35980, wrap at W0+36000
    step(599);
    chk("min1_hex2", sw_if.HEX2, SEG[1]);
    chk("min1_hex1", sw_if.HEX1, SEG[0]);
    step(35380);
    chk("t5958_hex3", sw_if.HEX3, SEG[5]);
    chk("t5958_hex2", sw_if.HEX2, SEG[9]);
    chk("t5958_hex1", sw_if.HEX1, SEG[5]);
    chk("t5958_hex0", sw_if.HEX0, SEG[8]);
    chk_bit("t5958_wrap", sw_if.WRAP, 1'b0);
    step(19);
    chk("t5959_hex0", sw_if.HEX0, SEG[9]);
    chk_bit("t5959_wrap", sw_if.WRAP, 1'b0);
    step(1);
    chk("wrap_hex0", sw_if.HEX0, SEG[0]);
    chk("wrap_hex1", sw_if.HEX1, SEG[0]);
    chk("wrap_hex2", sw_if.HEX2, SEG[0]);
    chk("wrap_hex3", sw_if.HEX3, SEG[0]);
    chk_bit("wrap_pulse", sw_if.WRAP, 1'b1);
    step(1);
    chk_bit("wrap_end", sw_if.WRAP, 1'b0);

    // Pause at 00:01, then LR clears back to IDLE
    step(10);
    sw_if.KEY_SS_N = 1'b0;
    step(7);
    chk_bit("pause3_run", sw_if.RUN_LED, 1'b0);
    chk("pause3_hex0", sw_if.HEX0, SEG[1]);
    step(1);
    sw_if.KEY_SS_N = 1'b1;
    step(10);
    sw_if.KEY_LR_N = 1'b0;
    step(7);
    chk_bit("clear_run", sw_if.RUN_LED, 1'b0);
    chk("clear_hex0", sw_if.HEX0, SEG[0]);
    sw_if.KEY_LR_N = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_CNT, default 50_000_000, SHALL set the CLK cycles per counted second.
REQ-002 Parameter DEB_CNT, default 1_000_000, SHALL set the debounce stability window in CLK cycles.
REQ-003 CLK  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 KEY_SS_N  input  1  SHALL be the asynchronous, active-low start/stop button.
REQ-006 KEY_LR_N  input  1  SHALL be the asynchronous, active-low lap/clear button.
REQ-007 HEX0..HEX3  output  7 each  SHALL drive active-low segments {g,f,e,d,c,b,a} for seconds-ones, seconds-tens, minutes-ones and minutes-tens respectively.
REQ-008 RUN_LED  output  1  SHALL be high in RUN or LAP.
REQ-009 LAP_LED  output  1  SHALL be high in LAP only.
REQ-010 WRAP  output  1  SHALL pulse high for one cycle when the count rolls over from 59:59 to 00:00.

Function
REQ-011 Each key SHALL pass through a 2-flop synchronizer, then a debouncer that accepts a new level only after it has been stable for DEB_CNT consecutive cycles.
REQ-012 A debounced high-to-low transition SHALL produce exactly one press pulse, lasting one cycle; release SHALL produce no pulse, and a held key SHALL produce no repeat.
REQ-013 The FSM SHALL have four states, IDLE, RUN, PAUSE and LAP, with the following transitions:
- IDLE: SS goes to RUN; LR is ignored.
- RUN: SS goes to PAUSE; LR goes to LAP and captures the live count.
- LAP: SS goes to PAUSE; LR goes to RUN.
- PAUSE: SS goes to RUN; LR goes to IDLE and clears the count and the prescaler.
REQ-014 When SS and LR press pulses occur in the same cycle, SS SHALL take priority and LR SHALL be discarded.
REQ-015 A state change SHALL take effect on the clock edge that samples the press pulse.
REQ-016 The prescaler SHALL behave as follows:
- RUN/LAP: counts 0..TICK_CNT-1, and a tick is asserted combinationally while it equals TICK_CNT-1, then wraps to 0.
- PAUSE: holds its value, so partial seconds are preserved.
- IDLE: held at 0.
REQ-017 On a tick the BCD count SHALL advance by one second on the same edge as the prescaler wrap:
- seconds-ones 0-9, seconds-tens 0-5, minutes-ones 0-9, minutes-tens 0-5;
- each carries into the next digit;
- 59:59 goes to 00:00 with WRAP=1 on the following cycle only.
REQ-018 The count SHALL advance only in RUN/LAP; it SHALL hold in PAUSE and be 00:00 in IDLE.
REQ-019 The display source SHALL be the live count in IDLE, RUN and PAUSE, and the lap-capture register in LAP.
REQ-020 Leaving LAP SHALL switch the display back to the live count on the transition edge.
REQ-021 The lap capture SHALL store the live count as it stands on the RUN-to-LAP edge, before any tick on that same edge.
REQ-022 Segment encoding for digits 0-9 SHALL be: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-023 Unreachable digit codes SHALL display blank (1111111).
REQ-024 HEX outputs SHALL be a combinational decode of the selected display register, so no extra latency is added.
REQ-025 RUN_LED and LAP_LED SHALL be decoded from the state register.

Reset
REQ-026 When RST=1, on the next CLK edge:
- state becomes IDLE;
- prescaler, count, lap register, debounced levels (set to released = 1) and synchronizers are all cleared;
- WRAP=0, RUN_LED=0, LAP_LED=0;
- HEX0..HEX3 = 1000000.
REQ-027 RST SHALL override all other activity in every state, including mid-debounce and mid-second.
REQ-028 A key held low through reset release SHALL NOT generate a press pulse until it has been released and pressed again.

Verification (TICK_CNT=10, DEB_CNT=4)
REQ-029 Reset, then press SS for 10 cycles -> RUN_LED=1 exactly 2+4+1 cycles after the first low sample; after 30 more cycles HEX0=0110000 (3 s).
REQ-030 Bounce KEY_SS_N low/high every 2 cycles for 20 cycles, then hold it high -> no press pulse and state unchanged.
REQ-031 RUN at 00:05 + 7 prescaler cycles, SS -> PAUSE; hold 50 cycles -> count frozen at 05; SS again -> 06 appears 3 cycles after the RUN edge.
REQ-032 RUN at 00:12, LR -> LAP_LED=1 and display frozen at 12 while live counting continues; after 40 cycles LR -> display shows 16.
REQ-033 Preload 59:58 in RUN -> after 20 cycles the display is 00:00 and WRAP is high for one cycle.
REQ-034 In PAUSE, SS and LR pulses in the same cycle -> RUN with count retained; also, RST asserted mid-LAP -> IDLE and all digits 0 on the next edge.
